mlp_act_sched: RTL and testbench

Time-multiplexed activation scheduler for the MLP datapath. It accepts one DIM-element signed vector per transaction and streams it, LANES elements per cycle, through a single shared one-cycle registered ReLU stage. It reassembles the results into an output buffer and presents the full vector downstream with a valid/ready handshake. It sits between a dense-layer accumulator output and the next layer's input, so a narrow activation unit can serve a wide layer.

---
 rtl/mlp_act_sched.sv | 134 +++++++++++++
 tb/tb_mlp_act_sched.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_act_sched.sv
// mlp_act_sched: streams one DIM-element vector through a shared LANES-wide
// registered ReLU stage, reassembles the result and hands it downstream.
module mlp_act_sched #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DIM    = 8,
    parameter int unsigned LANES  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] vec_in [0:DIM-1],
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] vec_out [0:DIM-1],
    output logic                     busy
);

    localparam int unsigned NCHUNK = DIM / LANES;
    localparam int unsigned CNT_W  = $clog2(NCHUNK) + 1;
    localparam int unsigned IDX_W  = (DIM > 1) ? $clog2(DIM) : 1;

    // Reject configurations where the vector does not split into whole chunks
    generate
        if ((DIM % LANES) != 0) begin : g_bad_cfg
            $error("mlp_act_sched: DIM must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          wb_idx;
    logic                      wb_valid;
    logic                      mode_r;
    logic                      accept;
    logic                      issue;
    logic signed [DATA_W-1:0]  in_buf  [0:DIM-1];
    logic signed [DATA_W-1:0]  stage_d [0:LANES-1];
    logic signed [DATA_W-1:0]  stage_q [0:LANES-1];

    assign accept = (state == IDLE) && in_valid && in_ready;
    assign issue  = (state == RUN);

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
        return (!x[DATA_W-1] && (x != '0)) ? x : '0;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (cnt == CNT_W'(NCHUNK - 1)) state_next = DRAIN;
            DRAIN:   state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Select the issued chunk and apply ReLU or pass-through
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            stage_d[l] = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            stage_d[l] = in_buf[IDX_W'(int'(cnt) * LANES + l)];
            if (mode_r) begin
                stage_d[l] = relu(stage_d[l]);
            end
        end
    end

    // Input capture, issue counter, shared stage and writeback into the output buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            wb_idx   <= '0;
            wb_valid <= 1'b0;
            mode_r   <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                in_buf[i]  <= '0;
                vec_out[i] <= '0;
            end
            for (int l = 0; l < LANES; l++) begin
                stage_q[l] <= '0;
            end
        end else begin
            if (accept) begin
                in_buf <= vec_in;
                mode_r <= relu_en;
                cnt    <= '0;
            end else if (issue) begin
                cnt <= cnt + CNT_W'(1);
            end
            wb_valid <= issue;
            wb_idx   <= cnt;
            if (issue) begin
                stage_q <= stage_d;
            end
            if (wb_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    vec_out[IDX_W'(int'(wb_idx) * LANES + l)] <= stage_q[l];
                end
            end
        end
    end

    // Registered handshake and status outputs, derived from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == OUT);
            busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_mlp_act_sched.sv
// Testbench for mlp_act_sched: directed and random vectors on a LANES=2 and a
// LANES=DIM instance, checked against a per-element ReLU model.
module tb_mlp_act_sched;

    localparam int unsigned DW  = 32;
    localparam int unsigned DIM = 4;

    typedef logic signed [DW-1:0] vec_t [0:DIM-1];

    logic clk;
    logic rst;

    logic a_in_valid, a_in_ready, a_relu_en, a_out_valid, a_out_ready, a_busy;
    vec_t a_vec_in, a_vec_out;
    logic b_in_valid, b_in_ready, b_relu_en, b_out_valid, b_out_ready, b_busy;
    vec_t b_vec_in, b_vec_out;

    int n_cmp;
    int n_err;

    mlp_act_sched #(.DATA_W(DW), .DIM(DIM), .LANES(2)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .vec_in(a_vec_in), .relu_en(a_relu_en),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .vec_out(a_vec_out), .busy(a_busy)
    );

    mlp_act_sched #(.DATA_W(DW), .DIM(DIM), .LANES(DIM)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .vec_in(b_vec_in), .relu_en(b_relu_en),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .vec_out(b_vec_out), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DIM*DW-1:0] pk(input vec_t v);
        logic [DIM*DW-1:0] r;
        r = '0;
        for (int i = 0; i < DIM; i++) r[(DIM-1-i)*DW +: DW] = v[i];
        return r;
    endfunction

    function automatic void mk(output vec_t v, input int x0, input int x1, input int x2, input int x3);
        v[0] = x0; v[1] = x1; v[2] = x2; v[3] = x3;
    endfunction

    // Reference: positive elements survive ReLU, everything else becomes zero
    function automatic void model(input vec_t v, input bit relu, output vec_t r);
        for (int i = 0; i < DIM; i++) r[i] = (relu && v[i] <= 32'sd0) ? 32'sd0 : v[i];
    endfunction

    function automatic void rand_vec(output vec_t v);
        for (int i = 0; i < DIM; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i] = 32'sd0;
                1:       v[i] = 32'sh8000_0000;
                default: v[i] = $urandom;
            endcase
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_a(input vec_t v, input bit relu);
        a_vec_in = v; a_relu_en = relu; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic wait_a(output int lat, output bit busy_ok);
        lat = -1; busy_ok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (a_busy !== 1'b1) busy_ok = 1'b0;
            if (a_out_valid === 1'b1) begin lat = c; break; end
        end
    endtask

    task automatic wait_b(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (b_out_valid === 1'b1) begin lat = c; break; end
        end
    endtask

    task automatic release_a();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit quiet;
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({a_out_valid, a_busy, a_in_ready, b_out_valid, b_busy, b_in_ready} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000",
                     {a_out_valid, a_busy, a_in_ready, b_out_valid, b_busy, b_in_ready});
        end
        n_cmp++;
        if (pk(a_vec_out) !== '0 || pk(b_vec_out) !== '0) begin
            n_err++;
            $display("FAIL reset_vec_out: got %h / %h want 0", pk(a_vec_out), pk(b_vec_out));
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({a_in_ready, b_in_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 11", {a_in_ready, b_in_ready});
        end
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_err++;
            $display("FAIL idle_no_out_valid: got out_valid while idle want 0");
        end
    endtask

    task automatic test_relu();
        vec_t v, e;
        int lat;
        bit bok;
        mk(v, 5, -3, 0, 32'sh8000_0000);
        mk(e, 5, 0, 0, 0);
        accept_a(v, 1'b1);
        n_cmp++;
        if ({a_busy, a_in_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL relu_accept_flags: got %b want 10", {a_busy, a_in_ready});
        end
        wait_a(lat, bok);
        n_cmp++;
        if (lat !== 3 || !bok) begin
            n_err++;
            $display("FAIL relu_latency: got lat=%0d busy_ok=%0b want lat=3 busy_ok=1", lat, bok);
        end
        n_cmp++;
        if (pk(a_vec_out) !== pk(e)) begin
            n_err++;
            $display("FAIL relu_result: got %h want %h", pk(a_vec_out), pk(e));
        end
        release_a();
        n_cmp++;
        if ({a_out_valid, a_busy, a_in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL relu_handshake: got %b want 001", {a_out_valid, a_busy, a_in_ready});
        end
    endtask

    task automatic test_bypass();
        vec_t v;
        int lat;
        bit bok;
        mk(v, 5, -3, 0, 32'sh8000_0000);
        accept_a(v, 1'b0);
        a_relu_en = 1'b1;
        wait_a(lat, bok);
        a_relu_en = 1'b0;
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL bypass_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if (pk(a_vec_out) !== pk(v)) begin
            n_err++;
            $display("FAIL bypass_result: got %h want %h", pk(a_vec_out), pk(v));
        end
        release_a();
    endtask

    task automatic test_backpressure();
        vec_t v1, v2, e1, e2;
        bit r2;
        int lat;
        bit bok;
        rand_vec(v1); rand_vec(v2);
        r2 = 1'($urandom_range(0, 1));
        model(v1, 1'b1, e1);
        model(v2, r2, e2);
        accept_a(v1, 1'b1);
        wait_a(lat, bok);
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL bp_first_latency: got %0d want 3", lat);
        end
        a_vec_in = v2; a_relu_en = r2; a_in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if ({a_out_valid, a_in_ready} !== 2'b10 || pk(a_vec_out) !== pk(e1)) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got v=%b r=%b %h want v=1 r=0 %h",
                         c, a_out_valid, a_in_ready, pk(a_vec_out), pk(e1));
            end
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        n_cmp++;
        if ({a_out_valid, a_busy, a_in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL bp_release: got %b want 001", {a_out_valid, a_busy, a_in_ready});
        end
        tick();
        a_in_valid = 1'b0;
        n_cmp++;
        if (a_busy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_second_accept: got busy=%b want 1", a_busy);
        end
        wait_a(lat, bok);
        n_cmp++;
        if (lat !== 3 || pk(a_vec_out) !== pk(e2)) begin
            n_err++;
            $display("FAIL bp_second_result: got lat=%0d %h want lat=3 %h", lat, pk(a_vec_out), pk(e2));
        end
        release_a();
    endtask

    task automatic test_reset_mid();
        vec_t v, w, e;
        int lat;
        bit bok;
        rand_vec(v);
        accept_a(v, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({a_out_valid, a_busy, a_in_ready} !== 3'b000 || pk(a_vec_out) !== '0) begin
            n_err++;
            $display("FAIL midreset_state: got %b %h want 000 0",
                     {a_out_valid, a_busy, a_in_ready}, pk(a_vec_out));
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_in_ready: got %b want 1", a_in_ready);
        end
        mk(w, -1, 7, 8, -9);
        mk(e, 0, 7, 8, 0);
        accept_a(w, 1'b1);
        wait_a(lat, bok);
        n_cmp++;
        if (lat !== 3 || pk(a_vec_out) !== pk(e)) begin
            n_err++;
            $display("FAIL midreset_next: got lat=%0d %h want lat=3 %h", lat, pk(a_vec_out), pk(e));
        end
        release_a();
    endtask

    task automatic test_back_to_back();
        vec_t cur, e;
        bit cr;
        vec_t expq[$];
        int acc_cyc[$];
        int n_acc, n_done;
        n_acc = 0; n_done = 0;
        rand_vec(cur);
        cr = 1'($urandom_range(0, 1));
        a_vec_in = cur; a_relu_en = cr; a_in_valid = 1'b1; a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && n_done < 20; cyc++) begin
            bit acc_now;
            if (a_out_valid === 1'b1) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_unexpected: got out_valid at cycle %0d want none", cyc);
                end else begin
                    if (pk(a_vec_out) !== pk(expq[0])) begin
                        n_err++;
                        $display("FAIL stream_result_%0d: got %h want %h", n_done, pk(a_vec_out), pk(expq[0]));
                    end
                    void'(expq.pop_front());
                end
                n_done++;
            end
            acc_now = a_in_valid && (a_in_ready === 1'b1);
            if (acc_now) begin
                model(cur, cr, e);
                expq.push_back(e);
                acc_cyc.push_back(cyc);
                n_acc++;
            end
            tick();
            if (acc_now) begin
                if (n_acc < 20) begin
                    rand_vec(cur);
                    cr = 1'($urandom_range(0, 1));
                    a_vec_in = cur; a_relu_en = cr;
                end else begin
                    a_in_valid = 1'b0;
                end
            end
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        n_cmp++;
        if (n_done !== 20 || n_acc !== 20) begin
            n_err++;
            $display("FAIL stream_count: got acc=%0d done=%0d want 20/20", n_acc, n_done);
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_cmp++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 5) begin
                n_err++;
                $display("FAIL stream_spacing_%0d: got %0d want 5", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        tick();
    endtask

    task automatic test_degenerate();
        vec_t v, e;
        int lat;
        n_cmp++;
        if (b_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL deg_in_ready: got %b want 1", b_in_ready);
        end
        mk(v, 1, -1, 2, -2);
        mk(e, 1, 0, 2, 0);
        b_vec_in = v; b_relu_en = 1'b1; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        wait_b(lat);
        n_cmp++;
        if (lat !== 2 || pk(b_vec_out) !== pk(e)) begin
            n_err++;
            $display("FAIL deg_relu: got lat=%0d %h want lat=2 %h", lat, pk(b_vec_out), pk(e));
        end
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        n_cmp++;
        if ({b_out_valid, b_in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL deg_handshake: got %b want 01", {b_out_valid, b_in_ready});
        end
        rand_vec(v);
        b_vec_in = v; b_relu_en = 1'b0; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        wait_b(lat);
        n_cmp++;
        if (lat !== 2 || pk(b_vec_out) !== pk(v)) begin
            n_err++;
            $display("FAIL deg_bypass: got lat=%0d %h want lat=2 %h", lat, pk(b_vec_out), pk(v));
        end
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        a_in_valid = 1'b0; a_relu_en = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_relu_en = 1'b0; b_out_ready = 1'b0;
        for (int i = 0; i < DIM; i++) begin
            a_vec_in[i] = '0;
            b_vec_in[i] = '0;
        end
        test_reset();
        test_relu();
        test_bypass();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_degenerate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
